// File: rtl/adc_frame_averager_pkg.sv
// -----------------------------------------------------------------------------
// adc_frame_averager_pkg
// Shared definitions for the ADC frame averager:
//   state_t      - control FSM encoding (idle / accumulate / latch)
//   acc_width()  - per-channel accumulator width, wide enough for a full block
//   C_MIN_INIT   - all-ones seed for the running-minimum trackers
// -----------------------------------------------------------------------------
package adc_frame_averager_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   // Widest sample the min-init constant can seed; callers slice it down.
   localparam int C_MAX_SAMPLE_BITS = 32;
   localparam logic [C_MAX_SAMPLE_BITS-1:0] C_MIN_INIT = '1;

   // Summing 2^avg_log2 samples of 'bits' width needs avg_log2 extra bits.
   function automatic int acc_width(input int bits, input int avg_log2);
      return bits + avg_log2;
   endfunction

endpackage

// File: rtl/adc_channel_stats.sv
// -----------------------------------------------------------------------------
// adc_channel_stats
// Single-channel block statistics: running sum, minimum and maximum, plus the
// result registers captured when a block completes.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   init_i          - reinitialise trackers (acc=0, min=all-ones, max=0)
//   acc_i           - fold sample_i into the running trackers
//   latch_i         - capture avg/min/max into results; restart trackers,
//                     seeding them with sample_i when dv_i is also high
//   dv_i, sample_i  - sample strobe and unsigned sample
//   res_avg_o/res_min_o/res_max_o - last latched block results
// -----------------------------------------------------------------------------
module adc_channel_stats
   import adc_frame_averager_pkg::*;
#(
   parameter int C_bits     = 12,
   parameter int C_avg_log2 = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_i,
   input  logic              acc_i,
   input  logic              latch_i,
   input  logic              dv_i,
   input  logic [C_bits-1:0] sample_i,
   output logic [C_bits-1:0] res_avg_o,
   output logic [C_bits-1:0] res_min_o,
   output logic [C_bits-1:0] res_max_o
);

   localparam int C_AW = acc_width(C_bits, C_avg_log2);
   localparam logic [C_bits-1:0] C_INIT_MIN = C_MIN_INIT[C_bits-1:0];

   logic [C_AW-1:0]   acc_q, acc_d;
   logic [C_bits-1:0] min_q, min_d;
   logic [C_bits-1:0] max_q, max_d;
   logic [C_bits-1:0] res_avg_q, res_avg_d;
   logic [C_bits-1:0] res_min_q, res_min_d;
   logic [C_bits-1:0] res_max_q, res_max_d;
   logic [C_AW-1:0]   sample_ext;

   assign sample_ext = C_AW'(sample_i);

   always_comb begin
      acc_d     = acc_q;
      min_d     = min_q;
      max_d     = max_q;
      res_avg_d = res_avg_q;
      res_min_d = res_min_q;
      res_max_d = res_max_q;
      if (init_i) begin
         acc_d = '0;
         min_d = C_INIT_MIN;
         max_d = '0;
      end else if (latch_i) begin
         // Truncating divide by 2^C_avg_log2 is just dropping the low bits.
         res_avg_d = acc_q[C_AW-1:C_avg_log2];
         res_min_d = min_q;
         res_max_d = max_q;
         if (dv_i) begin
            // A sample in the latch cycle opens the next block.
            acc_d = sample_ext;
            min_d = sample_i;
            max_d = sample_i;
         end else begin
            acc_d = '0;
            min_d = C_INIT_MIN;
            max_d = '0;
         end
      end else if (acc_i) begin
         acc_d = acc_q + sample_ext;
         if (sample_i < min_q) min_d = sample_i;
         if (sample_i > max_q) max_d = sample_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         min_q     <= C_INIT_MIN;
         max_q     <= '0;
         res_avg_q <= '0;
         res_min_q <= '0;
         res_max_q <= '0;
      end else begin
         acc_q     <= acc_d;
         min_q     <= min_d;
         max_q     <= max_d;
         res_avg_q <= res_avg_d;
         res_min_q <= res_min_d;
         res_max_q <= res_max_d;
      end
   end

   assign res_avg_o = res_avg_q;
   assign res_min_o = res_min_q;
   assign res_max_o = res_max_q;

endmodule

// File: rtl/adc_frame_averager.sv
// -----------------------------------------------------------------------------
// adc_frame_averager
// Box-car averages 2^C_avg_log2 samples per channel, tracks per-channel block
// min/max, and publishes the latest completed block only on a rising frame
// (vsync) edge so the display never changes mid-frame.
// Ports:
//   clk, rst_n  - pixel/ADC clock, asynchronous active-low reset
//   clken       - enable; low idles the block and discards partial/pending work
//   in_dv       - one-cycle strobe qualifying in_data
//   in_data     - packed samples, channel 0 in the LSBs
//   frame       - vsync level (same clock domain)
//   avg_data/min_data/max_data - published per-channel results
//   out_dv      - one-cycle pulse in the cycle the published outputs change
//   overrun     - sticky: a completed block was overwritten before publishing
// -----------------------------------------------------------------------------
module adc_frame_averager
   import adc_frame_averager_pkg::*;
#(
   parameter int C_channels = 4,
   parameter int C_bits     = 12,
   parameter int C_avg_log2 = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clken,
   input  logic                         in_dv,
   input  logic [C_channels*C_bits-1:0] in_data,
   input  logic                         frame,
   output logic [C_channels*C_bits-1:0] avg_data,
   output logic [C_channels*C_bits-1:0] min_data,
   output logic [C_channels*C_bits-1:0] max_data,
   output logic                         out_dv,
   output logic                         overrun
);

   localparam int C_W  = C_channels * C_bits;
   // One spare bit keeps the counter non-zero width when C_avg_log2 = 0.
   localparam int C_CW = C_avg_log2 + 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'((1 << C_avg_log2) - 1);

   state_t            state_q, state_d;
   logic [C_CW-1:0]   count_q, count_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              frame_q;
   logic              out_dv_q, out_dv_d;
   logic [C_W-1:0]    avg_q, avg_d;
   logic [C_W-1:0]    min_q, min_d;
   logic [C_W-1:0]    max_q, max_d;

   logic [C_W-1:0]    res_avg, res_min, res_max;
   logic              frame_edge;
   logic              publish;
   logic              take_sample;
   logic              stats_init, stats_acc, stats_latch;

   assign frame_edge = frame & ~frame_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      out_dv_d    = 1'b0;
      avg_d       = avg_q;
      min_d       = min_q;
      max_d       = max_q;
      publish     = 1'b0;
      take_sample = 1'b0;
      stats_init  = 1'b0;
      stats_acc   = 1'b0;
      stats_latch = 1'b0;

      if (!clken) begin
         state_d    = S_IDLE;
         count_d    = '0;
         pending_d  = 1'b0;
         overrun_d  = 1'b0;
         stats_init = 1'b1;
      end else begin
         publish = frame_edge & pending_q;

         case (state_q)
            S_IDLE: begin
               stats_init = 1'b1;
               state_d    = S_ACC;
            end
            S_ACC: begin
               take_sample = in_dv;
               stats_acc   = in_dv;
            end
            S_LATCH: begin
               stats_latch = 1'b1;
               take_sample = in_dv;
               state_d     = S_ACC;
               pending_d   = 1'b1;
               // A publish in this same cycle empties the old slot first.
               if (pending_q && !publish) overrun_d = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         if (take_sample) begin
            if (count_q == C_LAST) begin
               count_d = '0;
               state_d = S_LATCH;
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         // Result regs are read pre-latch, so a coincident latch publishes
         // the older block and leaves the new one pending.
         if (publish) begin
            avg_d    = res_avg;
            min_d    = res_min;
            max_d    = res_max;
            out_dv_d = 1'b1;
            if (state_q != S_LATCH) pending_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         frame_q   <= 1'b0;
         out_dv_q  <= 1'b0;
         avg_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         frame_q   <= frame;
         out_dv_q  <= out_dv_d;
         avg_q     <= avg_d;
         min_q     <= min_d;
         max_q     <= max_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < C_channels; gi++) begin : g_chan
         adc_channel_stats #(
            .C_bits     (C_bits),
            .C_avg_log2 (C_avg_log2)
         ) u_stats (
            .clk       (clk),
            .rst_n     (rst_n),
            .init_i    (stats_init),
            .acc_i     (stats_acc),
            .latch_i   (stats_latch),
            .dv_i      (in_dv),
            .sample_i  (in_data[gi*C_bits +: C_bits]),
            .res_avg_o (res_avg[gi*C_bits +: C_bits]),
            .res_min_o (res_min[gi*C_bits +: C_bits]),
            .res_max_o (res_max[gi*C_bits +: C_bits])
         );
      end
   endgenerate

   assign avg_data = avg_q;
   assign min_data = min_q;
   assign max_data = max_q;
   assign out_dv   = out_dv_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_frame_averager.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_averager
// Two instances: dut2 (4-sample blocks) and dut4 (16-sample blocks) sharing
// clock, reset, enable, frame and data; each has its own in_dv strobe.
// Inputs change on the falling edge, outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_frame_averager;

   localparam int CH = 4;
   localparam int B  = 12;
   localparam int W  = CH * B;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clken = 1'b0;
   logic         dv2 = 1'b0;
   logic         dv4 = 1'b0;
   logic         frame = 1'b0;
   logic [W-1:0] in_data = '0;

   logic [W-1:0] avg2, min2, max2, avg4, min4, max4;
   logic         odv2, ovr2, odv4, ovr4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adc_frame_averager #(.C_channels(CH), .C_bits(B), .C_avg_log2(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .in_dv(dv2), .in_data(in_data),
      .frame(frame), .avg_data(avg2), .min_data(min2), .max_data(max2),
      .out_dv(odv2), .overrun(ovr2)
   );

   adc_frame_averager #(.C_channels(CH), .C_bits(B), .C_avg_log2(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .in_dv(dv4), .in_data(in_data),
      .frame(frame), .avg_data(avg4), .min_data(min4), .max_data(max4),
      .out_dv(odv4), .overrun(ovr4)
   );

   typedef struct {
      string            name;
      logic [3:0][W-1:0] s;
      logic [W-1:0]     e_avg;
      logic [W-1:0]     e_min;
      logic [W-1:0]     e_max;
   } vec_t;

   vec_t vecs [3];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   task automatic send(input int sel, input logic [W-1:0] d);
      in_data = d;
      if (sel == 4) dv4 = 1'b1;
      else          dv2 = 1'b1;
      @(negedge clk);
      dv2 = 1'b0;
      dv4 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_pulse(input int sel, input string name, input logic exp_dv,
                              input logic [W-1:0] ea, input logic [W-1:0] emn,
                              input logic [W-1:0] emx);
      frame = 1'b1;
      @(negedge clk);
      check({name, " out_dv"}, W'(sel == 4 ? odv4 : odv2), W'(exp_dv));
      check({name, " avg"}, sel == 4 ? avg4 : avg2, ea);
      check({name, " min"}, sel == 4 ? min4 : min2, emn);
      check({name, " max"}, sel == 4 ? max4 : max2, emx);
      frame = 1'b0;
      @(negedge clk);
      check({name, " out_dv low"}, W'(sel == 4 ? odv4 : odv2), W'(1'b0));
   endtask

   initial begin
      vecs[0].name  = "flat800";
      vecs[0].s     = {48'h800800800800, 48'h800800800800, 48'h800800800800, 48'h800800800800};
      vecs[0].e_avg = 48'h800800800800;
      vecs[0].e_min = 48'h800800800800;
      vecs[0].e_max = 48'h800800800800;

      // s[0] is sent first. ch0: 0,1,2,5  ch1: 100 x4  ch2: FFF,0,FFF,0  ch3: 10..40
      vecs[1].name  = "mixed";
      vecs[1].s     = {48'h040000100005, 48'h030FFF100002, 48'h020000100001, 48'h010FFF100000};
      vecs[1].e_avg = 48'h0287FF100002;
      vecs[1].e_min = 48'h010000100000;
      vecs[1].e_max = 48'h040FFF100005;

      // Truncation: ch0 sum 3 -> 0, ch1 sum 11 -> 2, ch3 sum 34 -> 8.
      vecs[2].name  = "trunc";
      vecs[2].s     = {48'h00AABC002000, 48'h009ABC003001, 48'h008ABC003001, 48'h007ABC003001};
      vecs[2].e_avg = 48'h008ABC002000;
      vecs[2].e_min = 48'h007ABC002000;
      vecs[2].e_max = 48'h00AABC003001;

      // Reset state
      idle(2);
      check("reset avg2", avg2, '0);
      check("reset min2", min2, '0);
      check("reset max2", max2, '0);
      check("reset avg4", avg4, '0);
      check("reset out_dv2", W'(odv2), '0);
      check("reset overrun2", W'(ovr2), '0);
      rst_n = 1'b1;
      clken = 1'b1;
      idle(1);

      // Table-driven 4-sample blocks, each published on its own frame edge.
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 4; k++) send(2, vecs[v].s[k]);
         idle(1);
         frame_pulse(2, vecs[v].name, 1'b1, vecs[v].e_avg, vecs[v].e_min, vecs[v].e_max);
      end

      // 16 full-scale samples: accumulator must not wrap.
      for (int k = 0; k < 16; k++) send(4, 48'hFFFFFFFFFFFF);
      idle(1);
      frame_pulse(4, "fullscale16", 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
      frame_pulse(4, "no_pending", 1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);

      // Two blocks before one edge -> overrun, second block published.
      for (int k = 0; k < 4; k++) send(2, 48'h111111111111);
      idle(1);
      check("overrun after 1 block", W'(ovr2), '0);
      for (int k = 0; k < 4; k++) send(2, 48'h222222222222);
      idle(1);
      check("overrun after 2 blocks", W'(ovr2), W'(1'b1));
      frame_pulse(2, "overrun publish", 1'b1, 48'h222222222222, 48'h222222222222, 48'h222222222222);
      check("overrun sticky", W'(ovr2), W'(1'b1));
      clken = 1'b0;
      @(negedge clk);
      clken = 1'b1;
      check("overrun cleared", W'(ovr2), '0);
      check("avg hold over clken", avg2, 48'h222222222222);
      idle(1);
      frame_pulse(2, "after flush", 1'b0, 48'h222222222222, 48'h222222222222, 48'h222222222222);

      // Latch coincident with frame edge and a new sample.
      for (int k = 0; k < 4; k++) send(2, 48'h333333333333);
      idle(1);
      for (int k = 0; k < 4; k++) send(2, 48'h444444444444);
      frame   = 1'b1;
      in_data = 48'h555555555555;
      dv2     = 1'b1;
      @(negedge clk);
      dv2 = 1'b0;
      check("coincident out_dv", W'(odv2), W'(1'b1));
      check("coincident avg old", avg2, 48'h333333333333);
      check("coincident overrun", W'(ovr2), '0);
      frame = 1'b0;
      @(negedge clk);
      frame_pulse(2, "pending new block", 1'b1, 48'h444444444444, 48'h444444444444, 48'h444444444444);
      send(2, 48'h555555555555);
      send(2, 48'h555555555555);
      send(2, 48'h559559559559);
      idle(1);
      frame_pulse(2, "block from latch sample", 1'b1, 48'h556556556556, 48'h555555555555, 48'h559559559559);

      // Asynchronous reset mid-block.
      send(2, 48'h999999999999);
      send(2, 48'h999999999999);
      #1 rst_n = 1'b0;
      #1;
      check("async reset avg2", avg2, '0);
      check("async reset max2", max2, '0);
      check("async reset avg4", avg4, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) send(2, 48'h123123123123);
      idle(1);
      frame_pulse(2, "post reset", 1'b1, 48'h123123123123, 48'h123123123123, 48'h123123123123);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_frame_averager.md
Name: adc_frame_averager

Overview:
- Sits directly downstream of the MAX1112x ADC reader, in the ADC clock domain (pixel clock), and upstream of the on-screen hex display.
- Box-car averages 2^C_avg_log2 samples per channel and tracks min/max per channel over each block.
- Publishes results only on a frame (vsync) rising edge, so the display never changes mid-frame.
- Replaces the ad-hoc single-channel hold register in the top level.

Parameters:
- C_channels, 4, number of ADC channels packed in the input word.
- C_bits, 12, bits per channel sample, unsigned.
- C_avg_log2, 4, log2 of samples per averaging block (legal range 0..8).

Ports:
- clk  in  1  ADC/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  block enable; low = idle/flush.
- in_dv  in  1  one-cycle strobe, in_data valid.
- in_data  in  C_channels*C_bits  channel 0 in LSBs.
- frame  in  1  vsync level, same clock domain.
- avg_data  out  C_channels*C_bits  published per-channel averages.
- min_data  out  C_channels*C_bits  published per-channel block minimum.
- max_data  out  C_channels*C_bits  published per-channel block maximum.
- out_dv  out  1  one-cycle pulse, coincident with the cycle the outputs change.
- overrun  out  1  sticky; a completed block was discarded unpublished. Cleared by reset or clken low.

Behaviour:
- Reset: all outputs 0, internal accumulators/count 0, min trackers all-ones, max trackers 0, FSM = S_IDLE, result-pending flag 0.
- Per-channel accumulator width is C_bits+C_avg_log2, so it cannot overflow. Average = accumulator >> C_avg_log2 (truncate, no rounding).
- S_IDLE: entered whenever clken=0, from any state. Clears accumulators, count, min/max trackers, pending flag and overrun; in_dv ignored. Published outputs hold their last values. Leaves to S_ACC when clken=1.
- S_ACC, on in_dv:
  - acc += sample; min/max updated; count++.
  - When the sample is number 2^C_avg_log2 (count wraps to 0), go to S_LATCH.
- S_LATCH (one cycle):
  - result regs <= acc>>N, min, max. If pending was already 1, set overrun.
  - pending <= 1.
  - Trackers reinitialised.
  - An in_dv arriving in this same cycle is the first sample of the next block: acc <= sample, min = max = sample, count = 1.
  - Return to S_ACC.
- Frame edge: frame registered once; edge = frame & ~frame_q.
  - On an edge with pending=1: avg/min/max_data <= result regs, out_dv=1 in that cycle (registered), pending <= 0.
  - On an edge with pending=0: nothing changes and out_dv stays 0.
- Simultaneous S_LATCH and frame edge: the publish uses the result regs from before this cycle's latch (old result). The new result stays pending for the next edge. Overrun logic sees pending as its pre-edge value cleared by the publish, so overrun is not set.
- Latency: a block's last in_dv, +1 cycle to S_LATCH, +1 cycle before it is publishable. Earliest out_dv is 2 cycles after the last in_dv if a frame edge is detected then.
- C_avg_log2=0: every sample is a complete block; min = max = avg.
- clken falling mid-block discards the partial block. Falling between latch and frame edge discards the pending result.
- Asynchronous reset asserted mid-block behaves as power-on: outputs return to 0 immediately.

Decomposition:
- Shared package holds the FSM state encoding (S_IDLE, S_ACC, S_LATCH), the accumulator-width function (C_bits+C_avg_log2), and the all-ones min-init constant.
- One natural sub-module: adc_channel_stats. It covers a single channel's accumulator, min and max, with init/accumulate/latch controls, and is instantiated C_channels times in a generate loop.
- FSM, counter, frame edge detect and publish logic live in the top of the block.

Test Plan:
- C_avg_log2=2: all channels 0x800 ×4 in_dv, then frame rising edge -> out_dv pulse; avg/min/max all 0x800 per channel.
- C_avg_log2=2: channel 0 samples 0x000, 0x001, 0x002, 0x005 -> after edge, avg0=0x002, min0=0x000, max0=0x005; other channels independent.
- C_avg_log2=4: 16 samples of 0xFFF -> avg=0xFFF, no wrap. Then frame edge with no new block -> out_dv stays 0, outputs unchanged.
- Two blocks complete before one frame edge -> overrun=1; published values are from the second block. Then clken low for 1 cycle -> overrun=0 and outputs hold.
- S_LATCH coincident with a frame edge and with a new in_dv -> old result published; the new sample starts the next block with count=1. The following edge publishes the just-latched block.
- rst_n low mid-block (2 of 4 samples) -> outputs 0 asynchronously. After release, 4 fresh samples of 0x123 plus an edge -> avg 0x123 (no residue from the partial block).
